// File: rtl/instr_fetch_buf.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_buf
// Purpose  : Instruction fetch / prefetch buffer. On start, streams n_instr
//            words from the instruction SRAM beginning at base_instr_addr.
//            Reads are credit-limited so that words returning from the
//            fixed-latency SRAM pipeline always fit in a small FIFO. The
//            controller drains the FIFO through a valid/ready handshake.
// Ports    : clk, rst (async, active-high)
//            start, base_instr_addr, n_instr   - fetch request
//            mem_rd_en, mem_rd_addr, mem_rd_data - SRAM read port
//            instr, instr_vld, instr_rdy        - controller handshake
//            busy, done, stall_cnt              - status
// Config   : INSTR_FETCH_STALL_CNT_EN enables the saturating starvation
//            counter on stall_cnt; otherwise stall_cnt is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_buf #(
    parameter int INSTR_L      = 32,
    parameter int INSTR_ADDR_L = 16,
    parameter int DEPTH        = 4,
    parameter int MEM_RD_LAT   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [INSTR_ADDR_L-1:0] base_instr_addr,
    input  logic [INSTR_ADDR_L-1:0] n_instr,
    output logic                    mem_rd_en,
    output logic [INSTR_ADDR_L-1:0] mem_rd_addr,
    input  logic [INSTR_L-1:0]      mem_rd_data,
    output logic [INSTR_L-1:0]      instr,
    output logic                    instr_vld,
    input  logic                    instr_rdy,
    output logic                    busy,
    output logic                    done,
    output logic [31:0]             stall_cnt
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    // Occupancy (fifo + inflight) can reach 2*DEPTH transiently in the sum.
    localparam int c_OCC_W = c_CNT_W + 1;
    localparam logic [c_OCC_W-1:0] c_DEPTH_OCC = c_OCC_W'(DEPTH);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_FETCH = 2'd1;
    localparam logic [1:0] c_S_DRAIN = 2'd2;

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;

    logic [INSTR_ADDR_L-1:0] r_rd_ptr;
    logic [INSTR_ADDR_L-1:0] r_remaining;
    logic                    r_mem_rd_en;
    logic [INSTR_ADDR_L-1:0] r_mem_rd_addr;
    logic [MEM_RD_LAT-1:0]   r_tag;
    logic [c_CNT_W-1:0]      r_inflight;
    logic [c_CNT_W-1:0]      r_fifo_cnt;
    logic [c_PTR_W-1:0]      r_wr_idx;
    logic [c_PTR_W-1:0]      r_rd_idx;
    logic [INSTR_L-1:0]      r_mem [DEPTH];
    logic                    r_done;

    logic                    w_pop;
    logic                    w_push;
    logic [c_OCC_W-1:0]      w_occ;
    logic                    w_start_go;
    logic                    w_issue;
    logic [INSTR_ADDR_L-1:0] w_issue_addr;
    logic [INSTR_ADDR_L-1:0] w_issue_rem;
    logic                    w_last_issue;
    logic [c_CNT_W-1:0]      w_inflight_nxt;
    logic [c_CNT_W-1:0]      w_fifo_cnt_nxt;
    logic                    w_drained;
    logic                    w_done_nxt;

    // ------------------------------------------------------------------
    // Issue / credit control
    // ------------------------------------------------------------------
    assign w_pop  = instr_vld && instr_rdy;
    // The oldest tag bit marks that mem_rd_data carries a requested word now.
    assign w_push = r_tag[MEM_RD_LAT-1];

    // A pop this cycle frees a slot that a read may claim in the same cycle.
    assign w_occ = c_OCC_W'(r_fifo_cnt) - c_OCC_W'(w_pop) + c_OCC_W'(r_inflight);

    // The first read is decided in the start cycle so that the registered
    // strobe appears together with busy one cycle later.
    assign w_start_go   = (r_state == c_S_IDLE) && start && (n_instr != '0);
    assign w_issue      = w_start_go || ((r_state == c_S_FETCH) && (w_occ < c_DEPTH_OCC));
    assign w_issue_addr = w_start_go ? base_instr_addr : r_rd_ptr;
    assign w_issue_rem  = w_start_go ? n_instr : r_remaining;
    assign w_last_issue = w_issue && (w_issue_rem == INSTR_ADDR_L'(1));

    assign w_inflight_nxt = r_inflight + c_CNT_W'(w_issue) - c_CNT_W'(w_push);
    assign w_fifo_cnt_nxt = r_fifo_cnt + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    // Evaluated on next-cycle values so done and !busy land together.
    assign w_drained      = (w_inflight_nxt == '0) && (w_fifo_cnt_nxt == '0);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_start_go) begin
                    w_state_nxt = w_last_issue ? c_S_DRAIN : c_S_FETCH;
                end
            end
            c_S_FETCH: begin
                if (w_last_issue) begin
                    w_state_nxt = c_S_DRAIN;
                end
            end
            c_S_DRAIN: begin
                if (w_drained) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy       = (r_state != c_S_IDLE);
        w_done_nxt = 1'b0;
        case (r_state)
            c_S_IDLE:  w_done_nxt = start && (n_instr == '0);
            c_S_DRAIN: w_done_nxt = w_drained;
            default:   w_done_nxt = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr      <= '0;
            r_remaining   <= '0;
            r_mem_rd_en   <= 1'b0;
            r_mem_rd_addr <= '0;
            r_tag         <= '0;
            r_inflight    <= '0;
            r_fifo_cnt    <= '0;
            r_wr_idx      <= '0;
            r_rd_idx      <= '0;
            r_done        <= 1'b0;
        end else begin
            r_mem_rd_en <= w_issue;
            if (w_issue) begin
                r_mem_rd_addr <= w_issue_addr;
                r_rd_ptr      <= w_issue_addr + INSTR_ADDR_L'(1);
                r_remaining   <= w_issue_rem - INSTR_ADDR_L'(1);
            end
            r_tag      <= (r_tag << 1) | MEM_RD_LAT'(r_mem_rd_en);
            r_inflight <= w_inflight_nxt;
            r_fifo_cnt <= w_fifo_cnt_nxt;
            if (w_push) begin
                r_wr_idx <= r_wr_idx + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_idx <= r_rd_idx + c_PTR_W'(1);
            end
            r_done <= w_done_nxt;
        end
    end

    // FIFO storage needs no reset: entries are only observed when counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_idx] <= mem_rd_data;
        end
    end

    assign mem_rd_en   = r_mem_rd_en;
    assign mem_rd_addr = r_mem_rd_addr;
    assign instr_vld   = (r_fifo_cnt != '0);
    assign instr       = instr_vld ? r_mem[r_rd_idx] : '0;
    assign done        = r_done;

    // ------------------------------------------------------------------
    // Starvation statistic
    // ------------------------------------------------------------------
`ifdef INSTR_FETCH_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if ((r_state == c_S_IDLE) && start) begin
            r_stall_cnt <= '0;
        end else if (busy && instr_rdy && !instr_vld && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_buf
// Purpose  : Directed self-checking bench for instr_fetch_buf. One instance
//            uses a 1-cycle SRAM, a second uses a 3-cycle SRAM for the
//            starvation statistic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_buf;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // Instance with MEM_RD_LAT = 1, DEPTH = 4
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [15:0] n_words = '0;
    logic        mem_rd_en;
    logic [15:0] mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic [31:0] instr;
    logic        instr_vld;
    logic        instr_rdy = 1'b1;
    logic        busy;
    logic        done;
    logic [31:0] stall_cnt;

    // Instance with MEM_RD_LAT = 3, DEPTH = 8
    logic        start3 = 1'b0;
    logic [15:0] base_addr3 = '0;
    logic [15:0] n_words3 = '0;
    logic        mem_rd_en3;
    logic [15:0] mem_rd_addr3;
    logic [31:0] mem_rd_data3;
    logic [31:0] instr3;
    logic        instr_vld3;
    logic        instr_rdy3 = 1'b1;
    logic        busy3;
    logic        done3;
    logic [31:0] stall_cnt3;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t0       = 0;
    int t0_3     = 0;
    logic mon_clr  = 1'b0;
    logic mon_clr3 = 1'b0;

    logic [15:0] rd_addr_q[$];
    int          rd_cyc_q[$];
    logic [31:0] wd_q[$];
    int          wd_cyc_q[$];
    int          done_q[$];
    logic        done_busy;
    logic        busy_seen;

    int          wd_cyc3_q[$];
    int          done3_q[$];

    instr_fetch_buf #(
        .INSTR_L(32), .INSTR_ADDR_L(16), .DEPTH(4), .MEM_RD_LAT(1)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .base_instr_addr(base_addr), .n_instr(n_words),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .instr(instr), .instr_vld(instr_vld), .instr_rdy(instr_rdy),
        .busy(busy), .done(done), .stall_cnt(stall_cnt)
    );

    instr_fetch_buf #(
        .INSTR_L(32), .INSTR_ADDR_L(16), .DEPTH(8), .MEM_RD_LAT(3)
    ) u_dut3 (
        .clk(clk), .rst(rst), .start(start3),
        .base_instr_addr(base_addr3), .n_instr(n_words3),
        .mem_rd_en(mem_rd_en3), .mem_rd_addr(mem_rd_addr3), .mem_rd_data(mem_rd_data3),
        .instr(instr3), .instr_vld(instr_vld3), .instr_rdy(instr_rdy3),
        .busy(busy3), .done(done3), .stall_cnt(stall_cnt3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {~a, a};
    endfunction

    // SRAM models: no reset, so reads in flight at reset still return data.
    always @(posedge clk) mem_rd_data <= mem_rd_en ? mem_word(mem_rd_addr) : 32'hDEAD_BEEF;

    logic [31:0] p3_0, p3_1, p3_2;
    always @(posedge clk) begin
        p3_0 <= mem_rd_en3 ? mem_word(mem_rd_addr3) : 32'hDEAD_BEEF;
        p3_1 <= p3_0;
        p3_2 <= p3_1;
    end
    assign mem_rd_data3 = p3_2;

    // Observation logs, cycle numbers relative to the start cycle.
    always @(negedge clk) begin
        if (mon_clr) begin
            rd_addr_q.delete();
            rd_cyc_q.delete();
            wd_q.delete();
            wd_cyc_q.delete();
            done_q.delete();
            busy_seen = 1'b0;
            done_busy = 1'b1;
        end
        if (mem_rd_en) begin
            rd_addr_q.push_back(mem_rd_addr);
            rd_cyc_q.push_back(cyc - t0);
        end
        if (instr_vld && instr_rdy) begin
            wd_q.push_back(instr);
            wd_cyc_q.push_back(cyc - t0);
        end
        if (done) begin
            done_q.push_back(cyc - t0);
            done_busy = busy;
        end
        if (busy) busy_seen = 1'b1;
    end

    always @(negedge clk) begin
        if (mon_clr3) begin
            wd_cyc3_q.delete();
            done3_q.delete();
        end
        if (instr_vld3 && instr_rdy3) wd_cyc3_q.push_back(cyc - t0_3);
        if (done3) done3_q.push_back(cyc - t0_3);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Leaves the caller at cycle 1 (just after the edge that samples start).
    task automatic start_fetch(input logic [15:0] b, input logic [15:0] n);
        @(posedge clk); #1;
        mon_clr   = 1'b1;
        t0        = cyc;
        start     = 1'b1;
        base_addr = b;
        n_words   = n;
        @(posedge clk); #1;
        start   = 1'b0;
        mon_clr = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (done_q.size() != 0) break;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_stream(input string tag, input logic [15:0] b, input int cnt);
        check({tag, "_nrd"}, 32'(rd_addr_q.size()), 32'(cnt));
        check({tag, "_nwd"}, 32'(wd_q.size()), 32'(cnt));
        for (int i = 0; i < cnt; i++) begin
            logic [15:0] a;
            a = b + 16'(i);
            check($sformatf("%s_addr%0d", tag, i),
                  (i < rd_addr_q.size()) ? 32'(rd_addr_q[i]) : 32'hFFFF_FFFF, 32'(a));
            check($sformatf("%s_word%0d", tag, i),
                  (i < wd_q.size()) ? wd_q[i] : 32'hFFFF_FFFF, mem_word(a));
        end
    endtask

    initial begin
        // ---------------- Reset state ----------------
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rd_en",   32'(mem_rd_en), 32'd0);
        check("rst_rd_addr", 32'(mem_rd_addr), 32'd0);
        check("rst_instr",   instr, 32'd0);
        check("rst_vld",     32'(instr_vld), 32'd0);
        check("rst_busy",    32'(busy), 32'd0);
        check("rst_done",    32'(done), 32'd0);
        check("rst_stall",   stall_cnt, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ---------------- Streaming ----------------
        instr_rdy = 1'b1;
        start_fetch(16'h0010, 16'd8);
        wait_done(40);
        check_stream("stream", 16'h0010, 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("stream_rdcyc%0d", i),
                  (i < rd_cyc_q.size()) ? 32'(rd_cyc_q[i]) : 32'hFFFF_FFFF, 32'(1 + i));
            check($sformatf("stream_wdcyc%0d", i),
                  (i < wd_cyc_q.size()) ? 32'(wd_cyc_q[i]) : 32'hFFFF_FFFF, 32'(3 + i));
        end
        check("stream_ndone", 32'(done_q.size()), 32'd1);
        check("stream_done_cyc", (done_q.size() != 0) ? 32'(done_q[0]) : 32'hFFFF_FFFF, 32'd11);
        check("stream_busy_at_done", 32'(done_busy), 32'd0);

        // ---------------- Back-pressure + start while busy ----------------
        start_fetch(16'h0010, 16'd8);
        for (int k = 1; k < 40; k++) begin
            instr_rdy = !(k >= 3 && k <= 12);
            if (k == 6) begin
                start     = 1'b1;
                base_addr = 16'h0300;
                n_words   = 16'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (k == 8 || k == 12) begin
                check($sformatf("bp_vld_c%0d", k), 32'(instr_vld), 32'd1);
                check($sformatf("bp_hold_c%0d", k), instr, mem_word(16'h0010));
            end
            @(posedge clk); #1;
        end
        instr_rdy = 1'b1;
        check_stream("bp", 16'h0010, 8);
        check("bp_rdcyc3", (rd_cyc_q.size() > 3) ? 32'(rd_cyc_q[3]) : 32'hFFFF_FFFF, 32'd4);
        check("bp_rdcyc4", (rd_cyc_q.size() > 4) ? 32'(rd_cyc_q[4]) : 32'hFFFF_FFFF, 32'd14);
        check("bp_ndone", 32'(done_q.size()), 32'd1);

        // ---------------- Address wrap ----------------
        start_fetch(16'hFFFE, 16'd4);
        wait_done(30);
        check_stream("wrap", 16'hFFFE, 4);
        check("wrap_ndone", 32'(done_q.size()), 32'd1);

        // ---------------- Zero length ----------------
        start_fetch(16'h0050, 16'd0);
        repeat (3) @(posedge clk);
        #1;
        check("zero_ndone", 32'(done_q.size()), 32'd1);
        check("zero_done_cyc", (done_q.size() != 0) ? 32'(done_q[0]) : 32'hFFFF_FFFF, 32'd1);
        check("zero_nrd", 32'(rd_addr_q.size()), 32'd0);
        check("zero_busy", 32'(busy_seen), 32'd0);

        // ---------------- Reset mid-fetch ----------------
        start_fetch(16'h0100, 16'd8);
        @(posedge clk); #3;               // cycle 2, a word is due this cycle
        rst = 1'b1;
        #1;
        check("mrst_rd_en", 32'(mem_rd_en), 32'd0);
        check("mrst_rd_addr", 32'(mem_rd_addr), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_vld", 32'(instr_vld), 32'd0);
        check("mrst_instr", instr, 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_stall", stall_cnt, 32'd0);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check("mrst_late_c3", 32'(instr_vld), 32'd0);
        @(negedge clk);
        check("mrst_late_c4", 32'(instr_vld), 32'd0);
        check("mrst_idle_rd", 32'(mem_rd_en), 32'd0);
        start_fetch(16'h0200, 16'd3);
        wait_done(30);
        check_stream("post_rst", 16'h0200, 3);

        // ---------------- Starvation statistic (3-cycle SRAM) ----------------
        @(posedge clk); #1;
        mon_clr3   = 1'b1;
        t0_3       = cyc;
        start3     = 1'b1;
        base_addr3 = 16'h0040;
        n_words3   = 16'd1;
        @(posedge clk); #1;
        start3   = 1'b0;
        mon_clr3 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done3_q.size() != 0) break;
        end
        check("lat3_nwd", 32'(wd_cyc3_q.size()), 32'd1);
        check("lat3_vld_cyc", (wd_cyc3_q.size() != 0) ? 32'(wd_cyc3_q[0]) : 32'hFFFF_FFFF, 32'd5);
        check("lat3_done_cyc", (done3_q.size() != 0) ? 32'(done3_q[0]) : 32'hFFFF_FFFF, 32'd6);
`ifdef INSTR_FETCH_STALL_CNT_EN
        check("lat3_stall", stall_cnt3, 32'd4);
`else
        check("lat3_stall", stall_cnt3, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
